uart_hamming_receiver: RTL and testbench
========================================

# uart_hamming_receiver

- Downstream counterpart of the Hamming(7,4) encoder plus UART transmitter path.
- Receives 8N1 UART frames on a single serial line and extracts the 7-bit Hamming code word from each byte.
- Corrects any single-bit error, then presents the 4-bit payload with a one-cycle valid pulse and diagnostic flags.
- Sits between a `ui_in` pin (loopback of the TX output or an external source) and the top-level output bus.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit. Legal range is ≥ 4; it need not be even.

Ports:
- `clk` input 1: the single clock. Everything is rising-edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `rx` input 1: serial line. Idle is high.
- `data_out` output 4: decoded payload. Holds its value until the next good frame.
- `data_valid` output 1: 1-cycle pulse when `data_out`/`syndrome` update.
- `corrected` output 1: 1-cycle pulse coincident with `data_valid` when the syndrome is nonzero.
- `syndrome` output 3: syndrome of the last good frame, {s4,s2,s1}. Held.
- `frame_err` output 1: 1-cycle pulse when the stop bit samples low.
- `rx_busy` output 1: high in every state except IDLE.

## Operation

- **Synchronizer:** `rx` passes through 2 flops, both reset to 1. All logic uses the synchronized `rx_s`.
- **Byte format:** LSB first. Start bit 0, 8 data bits, 1 stop bit (1).
- **Code word:** byte[6:0] = c[6:0]. Byte bit 7 is padding and is ignored.
- **Code bit layout** (c0 = Hamming position 1): c0=p1, c1=p2, c2=d0, c3=p4, c4=d1, c5=d2, c6=d3.
- **Syndrome:**
  - s1 = c0^c2^c4^c6
  - s2 = c1^c2^c5^c6
  - s4 = c3^c4^c5^c6
  - s = {s4,s2,s1}. If s≠0, invert c[s-1] before extracting {d3,d2,d1,d0}.
  - Double errors are miscorrected silently; there is no detection of them.
- **FSM states:** IDLE, START, DATA, STOP, DECODE.
  - IDLE: `rx_s`==0 moves to START and clears the bit counter. The cycle counter loads (CLKS_PER_BIT-1)/2.
  - START: the counter counts down to 0, then `rx_s` is sampled. If 0, go to DATA with counter = CLKS_PER_BIT-1. If 1 (glitch), go back to IDLE with no output.
  - DATA: at counter 0, shift `rx_s` into the shift register MSB (right-shift) and reload the counter. After the 8th sample, go to STOP.
  - STOP: at counter 0, sample `rx_s`.
    - 1: go to DECODE.
    - 0: pulse `frame_err`, leave all other outputs untouched, and go to IDLE. If `rx_s` is still low, IDLE treats it as a new start edge on the next cycle.
  - DECODE: one cycle. Register `data_out` and `syndrome`, pulse `data_valid`, and pulse `corrected` if s≠0. Return to IDLE.
- **Counter width:** $clog2(CLKS_PER_BIT). Bit counter is 3 bits and wraps. No other arithmetic.

## Timing

- **Reset values:**
  - `data_out`=0, `syndrome`=0, `data_valid`=0, `corrected`=0, `frame_err`=0, `rx_busy`=0.
  - FSM goes to IDLE and the synchronizer flops are 1.
- **Reset mid-frame:** the frame is aborted immediately. No pulse is generated, and the partial shift register is discarded.
- **Sample points:** measured from the first cycle `rx_s`==0. Let H = (CLKS_PER_BIT-1)/2.
  - Start bit is sampled at cycle H.
  - Data bit k (k=0..7) is sampled at H + (k+1)·CLKS_PER_BIT.
  - Stop bit is sampled at H + 9·CLKS_PER_BIT.
- **Latency:** `data_valid` is high exactly one cycle after the stop-bit sample cycle. Measured from the `rx` pin edge, add 2 cycles of synchronizer latency.
- **Back-to-back frames:** a start bit arriving right after the stop bit is accepted with no idle cycle required, because DECODE completes within the stop bit.
- **Line noise:** an `rx` low held for H or fewer cycles produces no output.
- **Overlapping pulses:** `data_valid` and `frame_err` are never high in the same cycle.

## Test plan

- **Clean payload:** send 4'hB as byte 0x55, then 0x00 and 0x7F (CLKS_PER_BIT=16). Expect `data_out`=B, 0, F, each with one `data_valid` pulse, `syndrome`=0 and no `corrected`. Latency must match the Timing section exactly.
- **Single-bit correction:** send 0x45 (0x55 with c4 flipped). Expect `data_out`=B, `syndrome`=3'b101 and `corrected` pulsing with `data_valid`. Sweep a flip of every c0..c6 of 0x55 and expect `syndrome`=1..7 respectively with `data_out`=B every time.
- **Pad bit ignored:** send 0xD5. Expect `data_out`=B and `syndrome`=0.
- **Framing error:** send 0x55 with the stop bit driven 0. Expect one `frame_err` pulse, no `data_valid`, and `data_out` keeping its prior value. Then send a good 0x7F and expect `data_out`=F.
- **Glitch and reset:** a low pulse of 7 cycles on `rx` must give no busy beyond the START check and no output. Assert `rst_n` low during data bit 4: expect all outputs 0 asynchronously. The next full frame, 0x55, must then decode to B.
- **Back-to-back:** send 20 random payloads with zero idle between frames at CLKS_PER_BIT=5. Every payload must be received in order, with no `frame_err`.

Source files
------------

// File: rtl/uart_hamming_receiver.sv
// 8N1 UART receiver that extracts a Hamming(7,4) code word from each byte,
// corrects any single-bit error and presents the 4-bit payload with a valid pulse.
module uart_hamming_receiver #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [3:0] data_out,
    output logic       data_valid,
    output logic       corrected,
    output logic [2:0] syndrome,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DECODE
    } state_e;

    state_e          state_q, state_d;
    logic            rxMeta_q, rxSync_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bitCnt_q, bitCnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [3:0]      dataOut_q, dataOut_d;
    logic [2:0]      syndrome_q, syndrome_d;
    logic            dataValid_q, dataValid_d;
    logic            corrected_q, corrected_d;
    logic            frameErr_q, frameErr_d;

    logic [6:0]      code;
    logic [2:0]      synd;
    logic [6:0]      flipMask;
    logic [6:0]      fixedCode;

    // Syndrome of the assembled byte; the mask flips Hamming position s (bit s-1).
    always_comb begin
        code = shift_q[6:0];
        synd = {code[3] ^ code[4] ^ code[5] ^ code[6],
                code[1] ^ code[2] ^ code[5] ^ code[6],
                code[0] ^ code[2] ^ code[4] ^ code[6]};
        case (synd)
            3'd1:    flipMask = 7'b0000001;
            3'd2:    flipMask = 7'b0000010;
            3'd3:    flipMask = 7'b0000100;
            3'd4:    flipMask = 7'b0001000;
            3'd5:    flipMask = 7'b0010000;
            3'd6:    flipMask = 7'b0100000;
            3'd7:    flipMask = 7'b1000000;
            default: flipMask = 7'b0000000;
        endcase
        fixedCode = code ^ flipMask;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        dataOut_d   = dataOut_q;
        syndrome_d  = syndrome_q;
        dataValid_d = 1'b0;
        corrected_d = 1'b0;
        frameErr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rxSync_q) begin
                    state_d  = START;
                    cnt_d    = HALF;
                    bitCnt_d = 3'd0;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (!rxSync_q) begin
                        state_d = DATA;
                        cnt_d   = FULL;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d  = {rxSync_q, shift_q[7:1]};
                    cnt_d    = FULL;
                    bitCnt_d = bitCnt_q + 3'd1;
                    if (bitCnt_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            STOP: begin
                // Results load on the stop-sample edge so they are visible during DECODE.
                if (cnt_q == '0) begin
                    if (rxSync_q) begin
                        state_d     = DECODE;
                        dataOut_d   = {fixedCode[6], fixedCode[5], fixedCode[4], fixedCode[2]};
                        syndrome_d  = synd;
                        dataValid_d = 1'b1;
                        corrected_d = (synd != 3'd0);
                    end else begin
                        state_d    = IDLE;
                        frameErr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DECODE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxMeta_q    <= 1'b1;
            rxSync_q    <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bitCnt_q    <= 3'd0;
            shift_q     <= 8'd0;
            dataOut_q   <= 4'd0;
            syndrome_q  <= 3'd0;
            dataValid_q <= 1'b0;
            corrected_q <= 1'b0;
            frameErr_q  <= 1'b0;
        end else begin
            rxMeta_q    <= rx;
            rxSync_q    <= rxMeta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            dataOut_q   <= dataOut_d;
            syndrome_q  <= syndrome_d;
            dataValid_q <= dataValid_d;
            corrected_q <= corrected_d;
            frameErr_q  <= frameErr_d;
        end
    end

    assign data_out   = dataOut_q;
    assign syndrome   = syndrome_q;
    assign data_valid = dataValid_q;
    assign corrected  = corrected_q;
    assign frame_err  = frameErr_q;
    assign rx_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_hamming_receiver.sv
// Directed bench for uart_hamming_receiver: instance A runs at 16 clocks/bit,
// instance B at 5 clocks/bit for the back-to-back stream.
module tb_uart_hamming_receiver;

    localparam int NA = 16;
    localparam int HA = (NA - 1) / 2;
    localparam int NB = 5;
    // Pin edge to data_valid: 2 sync flops, 1 IDLE detect, H+1 start countdown, 9 bit times.
    localparam int LAT_A = HA + 9 * NA + 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxA = 1'b1;
    logic       rxB = 1'b1;
    logic [3:0] dataOutA, dataOutB;
    logic       dataValidA, dataValidB;
    logic       correctedA, correctedB;
    logic [2:0] syndromeA, syndromeB;
    logic       frameErrA, frameErrB;
    logic       rxBusyA, rxBusyB;

    int checks = 0;
    int passes = 0;
    int edgeCount = 0;
    int lastStart = 0;
    int aFrameErr = 0;
    int bFrameErr = 0;
    int overlaps = 0;
    int strayCorr = 0;
    int aBusyCycles = 0;

    logic [3:0] aData[$];
    logic [2:0] aSyn[$];
    logic       aCorr[$];
    int         aEdge[$];
    logic [3:0] bData[$];

    logic [7:0] flipBytes [7] = '{8'h54, 8'h57, 8'h51, 8'h5D, 8'h45, 8'h75, 8'h15};
    logic [3:0] payload [20] = '{4'h3, 4'hA, 4'h0, 4'hF, 4'h6, 4'h9, 4'h1, 4'hE, 4'h5, 4'hC,
                                 4'h7, 4'h8, 4'h2, 4'hD, 4'h4, 4'hB, 4'hF, 4'h0, 4'hA, 4'h5};

    uart_hamming_receiver #(.CLKS_PER_BIT(NA)) dutA (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rxA),
        .data_out   (dataOutA),
        .data_valid (dataValidA),
        .corrected  (correctedA),
        .syndrome   (syndromeA),
        .frame_err  (frameErrA),
        .rx_busy    (rxBusyA)
    );

    uart_hamming_receiver #(.CLKS_PER_BIT(NB)) dutB (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rxB),
        .data_out   (dataOutB),
        .data_valid (dataValidB),
        .corrected  (correctedB),
        .syndrome   (syndromeB),
        .frame_err  (frameErrB),
        .rx_busy    (rxBusyB)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeCount++;

    // Collect every output pulse on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        if (dataValidA) begin
            aData.push_back(dataOutA);
            aSyn.push_back(syndromeA);
            aCorr.push_back(correctedA);
            aEdge.push_back(edgeCount);
        end
        if (dataValidB) bData.push_back(dataOutB);
        if (frameErrA) aFrameErr++;
        if (frameErrB) bFrameErr++;
        if ((dataValidA && frameErrA) || (dataValidB && frameErrB)) overlaps++;
        if ((correctedA && !dataValidA) || (correctedB && !dataValidB)) strayCorr++;
        if (rxBusyA) aBusyCycles++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one 8N1 frame starting on a falling edge; returns on a falling edge.
    task automatic applyStimulus(input bit useB, input logic [7:0] data, input logic stopBit);
        logic [9:0] frame;
        frame = {stopBit, data, 1'b0};
        lastStart = edgeCount;
        for (int i = 0; i < 10; i++) begin
            if (useB) rxB = frame[i];
            else      rxA = frame[i];
            repeat (useB ? NB : NA) @(negedge clk);
        end
    endtask

    task automatic idle(input int cycles);
        rxA = 1'b1;
        rxB = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic expectFrame(input string tag, input logic [3:0] expData, input logic [2:0] expSyn,
                               input bit checkLatency);
        logic [3:0] d;
        logic [2:0] s;
        logic       c;
        int         e;
        if (aData.size() == 0) begin
            checkOutput({tag, "_valid"}, 32'd0, 32'd1);
        end else begin
            d = aData.pop_front();
            s = aSyn.pop_front();
            c = aCorr.pop_front();
            e = aEdge.pop_front();
            checkOutput({tag, "_data"}, 32'(d), 32'(expData));
            checkOutput({tag, "_syn"}, 32'(s), 32'(expSyn));
            checkOutput({tag, "_corr"}, 32'(c), (expSyn != 3'd0) ? 32'd1 : 32'd0);
            if (checkLatency) checkOutput({tag, "_lat"}, 32'(e - lastStart), 32'(LAT_A));
        end
    endtask

    function automatic logic [7:0] encode(input logic [3:0] d, input logic pad);
        logic p1, p2, p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {pad, d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    initial begin
        int feBefore;
        int busyBefore;
        logic [9:0] frame;

        // Reset values while rst_n is held low.
        repeat (3) @(negedge clk);
        checkOutput("rst_data", 32'(dataOutA), 32'd0);
        checkOutput("rst_syn", 32'(syndromeA), 32'd0);
        checkOutput("rst_valid", 32'(dataValidA), 32'd0);
        checkOutput("rst_corr", 32'(correctedA), 32'd0);
        checkOutput("rst_ferr", 32'(frameErrA), 32'd0);
        checkOutput("rst_busy", 32'(rxBusyA), 32'd0);
        rst_n = 1'b1;
        idle(4);

        // Clean code words.
        applyStimulus(1'b0, 8'h55, 1'b1); idle(2 * NA); expectFrame("clean55", 4'hB, 3'd0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1); idle(2 * NA); expectFrame("clean00", 4'h0, 3'd0, 1'b1);
        applyStimulus(1'b0, 8'h7F, 1'b1); idle(2 * NA); expectFrame("clean7F", 4'hF, 3'd0, 1'b1);

        // Every single-bit flip of 0x55 corrects back to B with syndrome = position.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, flipBytes[i], 1'b1);
            idle(2 * NA);
            expectFrame($sformatf("flip_c%0d", i), 4'hB, 3'(i + 1), 1'b0);
        end

        applyStimulus(1'b0, 8'hD5, 1'b1); idle(2 * NA); expectFrame("pad", 4'hB, 3'd0, 1'b0);

        // Stop bit low: one frame_err, no valid, data held.
        feBefore = aFrameErr;
        applyStimulus(1'b0, 8'h55, 1'b0);
        idle(3 * NA);
        checkOutput("ferr_count", 32'(aFrameErr - feBefore), 32'd1);
        checkOutput("ferr_novalid", 32'(aData.size()), 32'd0);
        checkOutput("ferr_hold", 32'(dataOutA), 32'hB);
        applyStimulus(1'b0, 8'h7F, 1'b1); idle(2 * NA); expectFrame("after_ferr", 4'hF, 3'd0, 1'b1);

        // A 7-cycle glitch is busy only for the H+1 start countdown cycles.
        busyBefore = aBusyCycles;
        rxA = 1'b0;
        repeat (7) @(negedge clk);
        idle(3 * NA);
        checkOutput("glitch_busy", 32'(aBusyCycles - busyBefore), 32'(HA + 1));
        checkOutput("glitch_novalid", 32'(aData.size()), 32'd0);
        checkOutput("glitch_idle", 32'(rxBusyA), 32'd0);

        applyStimulus(1'b0, 8'h15, 1'b1); idle(2 * NA); expectFrame("pre_rst", 4'hB, 3'd7, 1'b0);

        // Reset asserted in the middle of data bit 4.
        feBefore = aFrameErr;
        frame = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 5; i++) begin
            rxA = frame[i];
            repeat (NA) @(negedge clk);
        end
        rxA = frame[5];
        repeat (NA / 2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_data", 32'(dataOutA), 32'd0);
        checkOutput("midrst_syn", 32'(syndromeA), 32'd0);
        checkOutput("midrst_busy", 32'(rxBusyA), 32'd0);
        checkOutput("midrst_valid", 32'(dataValidA), 32'd0);
        @(negedge clk);
        rxA = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(3 * NA);
        checkOutput("midrst_novalid", 32'(aData.size()), 32'd0);
        checkOutput("midrst_noferr", 32'(aFrameErr - feBefore), 32'd0);
        applyStimulus(1'b0, 8'h55, 1'b1); idle(2 * NA); expectFrame("post_rst", 4'hB, 3'd0, 1'b1);

        // Back-to-back stream with no idle between frames on instance B.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, encode(payload[i], 1'(i % 2)), 1'b1);
        end
        idle(4 * NB);
        checkOutput("b2b_count", 32'(bData.size()), 32'd20);
        for (int i = 0; i < 20; i++) begin
            if (i < bData.size()) checkOutput($sformatf("b2b_%0d", i), 32'(bData[i]), 32'(payload[i]));
        end
        checkOutput("b2b_ferr", 32'(bFrameErr), 32'd0);

        checkOutput("overlap", 32'(overlaps), 32'd0);
        checkOutput("stray_corr", 32'(strayCorr), 32'd0);
        checkOutput("extra_valid", 32'(aData.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
